// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-variable type, FSM state type and sigma helpers.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned STATE_W = 256;
  localparam int unsigned ROUNDS  = 64;
  localparam int unsigned T_W     = 6;
  localparam int unsigned SCHED_N = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Field a occupies the MSBs so the struct lines up with the digest word order.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } work_t;

  localparam logic [WORD_W-1:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [STATE_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 compression engine.
interface sha256_compress_if;
  import sha256_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] block;
  logic [STATE_W-1:0] h_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] digest;
  logic               busy;

  modport master (
    output in_valid, block, h_in, out_ready,
    input  in_ready, out_valid, digest, busy
  );

  modport slave (
    input  in_valid, block, h_in, out_ready,
    output in_ready, out_valid, digest, busy
  );

endinterface

// File: rtl/sha256_bsig1.sv
// SHA-256 big-sigma-1: rotr6 ^ rotr11 ^ rotr25, applied to working variable e.
module sha256_bsig1
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  assign y_o = rotr(x_i, 6) ^ rotr(x_i, 11) ^ rotr(x_i, 25);

endmodule

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: maps a..h with K[t] and W[t] to the next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t             cur_i,
  input  logic [WORD_W-1:0] k_i,
  input  logic [WORD_W-1:0] w_i,
  output work_t             nxt_o
);

  logic [WORD_W-1:0] s1_c;
  logic [WORD_W-1:0] ch_c;
  logic [WORD_W-1:0] maj_c;
  logic [WORD_W-1:0] t1_c;
  logic [WORD_W-1:0] t2_c;

  sha256_bsig1 u_bsig1 (
    .x_i (cur_i.e),
    .y_o (s1_c)
  );

  assign ch_c  = (cur_i.e & cur_i.f) ^ (~cur_i.e & cur_i.g);
  assign maj_c = (cur_i.a & cur_i.b) ^ (cur_i.a & cur_i.c) ^ (cur_i.b & cur_i.c);

  // All sums wrap at 2^32 by construction of the 32-bit operands.
  assign t1_c = cur_i.h + s1_c + ch_c + k_i + w_i;
  assign t2_c = big_sigma0(cur_i.a) + maj_c;

  assign nxt_o.a = t1_c + t2_c;
  assign nxt_o.b = cur_i.a;
  assign nxt_o.c = cur_i.b;
  assign nxt_o.d = cur_i.c;
  assign nxt_o.e = cur_i.d + t1_c;
  assign nxt_o.f = cur_i.e;
  assign nxt_o.g = cur_i.f;
  assign nxt_o.h = cur_i.g;

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, digest 64 cycles after acceptance.
// Build option SHA256_FEEDFORWARD_EN adds the latched chaining value into the digest.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sha256_compress_if.slave bus
);

  state_e             state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  work_t              work_q, work_d;
  logic [WORD_W-1:0]  w_q [SCHED_N];
  logic [WORD_W-1:0]  w_d [SCHED_N];
  logic [STATE_W-1:0] digest_q, digest_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef SHA256_FEEDFORWARD_EN
  logic [STATE_W-1:0] hin_q, hin_d;
`endif

  work_t              round_nxt_c;
  logic [WORD_W-1:0]  w_new_c;
  logic [STATE_W-1:0] final_c;

  sha256_round u_round (
    .cur_i (work_q),
    .k_i   (K[t_q]),
    .w_i   (w_q[0]),
    .nxt_o (round_nxt_c)
  );

  assign w_new_c = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  // Value captured into the digest register on the last round.
  always_comb begin
    final_c = '0;
`ifdef SHA256_FEEDFORWARD_EN
    for (int i = 0; i < 8; i++) begin
      final_c[32*i +: 32] = round_nxt_c[32*i +: 32] + hin_q[32*i +: 32];
    end
`else
    final_c = round_nxt_c;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    work_d   = work_q;
    w_d      = w_q;
    digest_d = digest_q;
`ifdef SHA256_FEEDFORWARD_EN
    hin_d    = hin_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = ST_ROUND;
          t_d     = '0;
          work_d  = bus.h_in;
`ifdef SHA256_FEEDFORWARD_EN
          hin_d   = bus.h_in;
`endif
          for (int i = 0; i < 16; i++) begin
            w_d[i] = bus.block[BLOCK_W-1-32*i -: 32];
          end
        end
      end
      ST_ROUND: begin
        work_d = round_nxt_c;
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i+1];
        end
        w_d[15] = w_new_c;
        t_d     = t_q + T_W'(1);
        if (t_q == T_W'(ROUNDS - 1)) begin
          state_d  = ST_DONE;
          digest_d = final_c;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      work_q      <= '0;
      w_q         <= '{default: '0};
      digest_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SHA256_FEEDFORWARD_EN
      hin_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      work_q      <= work_d;
      w_q         <= w_d;
      digest_q    <= digest_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SHA256_FEEDFORWARD_EN
      hin_q       <= hin_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.digest    = digest_q;
  assign bus.busy      = busy_q;

endmodule
